// File: rtl/ws2812_encoder_pkg.sv
// timing_constants: shared timing constants, state encoding and pixel type
// for the WS2812 encoder. Cycle counts assume a 50 MHz system clock.
package timing_constants;

    // Bit timing in clock cycles; every bit period is 62 cycles.
    localparam int T0H_CYCLES   = 20;
    localparam int T0L_CYCLES   = 42;
    localparam int T1H_CYCLES   = 40;
    localparam int T1L_CYCLES   = 22;

    // Latch (reset) gap after a frame-last pixel: 50 us.
    localparam int RESET_CYCLES = 2500;

    // Default pixel word size and bit-index width.
    localparam int PIXEL_WIDTH_DEFAULT = 24;
    localparam int IDX_WIDTH           = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } enc_state_t;

    typedef logic [PIXEL_WIDTH_DEFAULT-1:0] pixel_word_t;

    // Length in cycles of the phase entered in state st for data bit bit_val.
    // IDLE has no timed phase, so it reports one cycle (counter loads 0).
    function automatic int phase_cycles(input enc_state_t st, input logic bit_val);
        case (st)
            HIGH:    phase_cycles = bit_val ? T1H_CYCLES : T0H_CYCLES;
            LOW:     phase_cycles = bit_val ? T1L_CYCLES : T0L_CYCLES;
            LATCH:   phase_cycles = RESET_CYCLES;
            default: phase_cycles = 1;
        endcase
    endfunction

endpackage

// File: rtl/ws2812_pixel_hold.sv
// ws2812_pixel_hold: one-entry holding register between the pixel producer
// and the encoder FSM. Stores {data, last} plus a full flag.
//
// Handshake: a transfer happens on a rising clock edge where valid && ready
// are both high. ready is simply "register empty", so it never depends on
// valid in the same cycle. The producer must keep data/last stable while
// valid is high and ready is low. An unload (i_unload) empties the register
// and ready rises on the following cycle; a transfer and an unload can never
// coincide because ready is low whenever there is something to unload.
module ws2812_pixel_hold
    import timing_constants::*;
#(
    parameter int PIXEL_WIDTH = 24
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [PIXEL_WIDTH-1:0] i_pixel_data,
    input  logic                   i_pixel_last,
    input  logic                   i_pixel_valid,
    output logic                   o_pixel_ready,
    input  logic                   i_unload,
    output logic [PIXEL_WIDTH-1:0] o_hold_data,
    output logic                   o_hold_last,
    output logic                   o_hold_full
);

    logic                   hold_full;
    logic [PIXEL_WIDTH-1:0] hold_data;
    logic                   hold_last;
    logic                   accept;

    assign accept = i_pixel_valid && !hold_full;

    // Capture on handshake, empty on unload; reset discards any held pixel.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hold_full <= 1'b0;
            hold_data <= '0;
            hold_last <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= i_pixel_data;
            hold_last <= i_pixel_last;
        end else if (i_unload) begin
            hold_full <= 1'b0;
        end
    end

    assign o_pixel_ready = !hold_full;
    assign o_hold_data   = hold_data;
    assign o_hold_last   = hold_last;
    assign o_hold_full   = hold_full;

endmodule

// File: rtl/ws2812_encoder.sv
// ws2812_encoder: serialises GRB pixel words (MSB first) onto the WS2812
// single-wire NRZ data line. Pixels queue in a one-entry holding register so
// consecutive pixels stream without a gap; a latch period follows any pixel
// flagged as frame-last.
// Optional feature: define WS2812_UNDERRUN_FLAG_EN to add the o_underrun
// output, a one-cycle pulse when the stream runs dry mid-frame.
module ws2812_encoder
    import timing_constants::*;
#(
    parameter int CNT_WIDTH   = 12,
    parameter int PIXEL_WIDTH = 24
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic [PIXEL_WIDTH-1:0] i_pixel_data,
    input  logic                   i_pixel_last,
    input  logic                   i_pixel_valid,
    output logic                   o_pixel_ready,
    output logic                   o_serial,
    output logic                   o_busy,
`ifdef WS2812_UNDERRUN_FLAG_EN
    output logic                   o_underrun,
`endif
    output enc_state_t             o_dbg_state
);

    // FSM state
    enc_state_t state;
    enc_state_t state_next;

    // Datapath
    logic [CNT_WIDTH-1:0]   phase_cnt;
    logic                   phase_done;
    logic [IDX_WIDTH-1:0]   bit_idx;
    logic [PIXEL_WIDTH-1:0] shifter;
    logic                   pixel_last_q;

    // Holding register interface
    logic [PIXEL_WIDTH-1:0] hold_data;
    logic                   hold_last;
    logic                   hold_full;
    logic                   hold_unload;

    // Per-cycle control decoded from the FSM
    logic                   shift_en;
    logic                   next_bit;

    ws2812_pixel_hold #(
        .PIXEL_WIDTH (PIXEL_WIDTH)
    ) u_hold (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_pixel_data  (i_pixel_data),
        .i_pixel_last  (i_pixel_last),
        .i_pixel_valid (i_pixel_valid),
        .o_pixel_ready (o_pixel_ready),
        .i_unload      (hold_unload),
        .o_hold_data   (hold_data),
        .o_hold_last   (hold_last),
        .o_hold_full   (hold_full)
    );

    // A timed phase finishes on the cycle its down-counter reads zero.
    assign phase_done = (phase_cnt == '0);

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: HIGH/LOW alternate per bit, end of pixel picks
    // latch, seamless reload, or fall back to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    state_next = HIGH;
                end
            end
            HIGH: begin
                if (phase_done) begin
                    state_next = LOW;
                end
            end
            LOW: begin
                if (phase_done) begin
                    if (bit_idx != '0) begin
                        state_next = HIGH;
                    end else if (pixel_last_q) begin
                        state_next = LATCH;
                    end else if (hold_full) begin
                        state_next = HIGH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            LATCH: begin
                if (phase_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output/control decode: busy flag, hold unload, shift, and the bit
    // value that the next phase will be timed against.
    always_comb begin
        o_busy      = (state != IDLE);
        hold_unload = 1'b0;
        shift_en    = 1'b0;
        case (state)
            IDLE: begin
                hold_unload = hold_full;
            end
            LOW: begin
                if (phase_done) begin
                    if (bit_idx != '0) begin
                        shift_en = 1'b1;
                    end else if (!pixel_last_q && hold_full) begin
                        hold_unload = 1'b1;
                    end
                end
            end
            default: begin
                hold_unload = 1'b0;
            end
        endcase

        if (hold_unload) begin
            next_bit = hold_data[PIXEL_WIDTH-1];
        end else if (shift_en) begin
            next_bit = shifter[PIXEL_WIDTH-2];
        end else begin
            next_bit = shifter[PIXEL_WIDTH-1];
        end
    end

    // Shifter, bit index and last flag: reload from hold or step one bit.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            shifter      <= '0;
            bit_idx      <= '0;
            pixel_last_q <= 1'b0;
        end else if (hold_unload) begin
            shifter      <= hold_data;
            bit_idx      <= IDX_WIDTH'(PIXEL_WIDTH - 1);
            pixel_last_q <= hold_last;
        end else if (shift_en) begin
            shifter      <= {shifter[PIXEL_WIDTH-2:0], 1'b0};
            bit_idx      <= bit_idx - IDX_WIDTH'(1);
        end
    end

    // Phase counter: loads (length-1) on every state change, then counts
    // down and holds at zero.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase_cnt <= '0;
        end else if (state_next != state) begin
            phase_cnt <= CNT_WIDTH'(phase_cycles(state_next, next_bit) - 1);
        end else if (!phase_done) begin
            phase_cnt <= phase_cnt - CNT_WIDTH'(1);
        end
    end

    // Registered data line, high exactly while the FSM sits in HIGH.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_serial <= 1'b0;
        end else begin
            o_serial <= (state_next == HIGH);
        end
    end

`ifdef WS2812_UNDERRUN_FLAG_EN
    logic underrun_evt;

    assign underrun_evt = (state == LOW) && phase_done && (bit_idx == '0) &&
                          !pixel_last_q && !hold_full;

    // One-cycle pulse aligned with the first IDLE cycle after an underrun.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= underrun_evt;
        end
    end
`endif

    assign o_dbg_state = state;

endmodule

// File: tb/tb_ws2812_encoder.sv
// tb_ws2812_encoder: self-checking bench for ws2812_encoder. A cycle-level
// reference waveform (serial, busy, end-of-non-last-pixel marker) is built
// from each accepted pixel and compared every cycle; directed tables and
// hand sequences check edge timings.
module tb_ws2812_encoder;
    import timing_constants::*;

    localparam int PW      = 24;
    localparam int B_T0H   = 20;
    localparam int B_T1H   = 40;
    localparam int B_BIT   = 62;
    localparam int B_LATCH = 2500;
    localparam int B_PIX   = 24 * 62;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #10 clk = ~clk;

    logic [PW-1:0] data  = '0;
    logic          last  = 1'b0;
    logic          valid = 1'b0;
    logic          ready;
    logic          serial;
    logic          busy;
    enc_state_t    dbg_state;
`ifdef WS2812_UNDERRUN_FLAG_EN
    logic          underrun;
`endif

    ws2812_encoder #(
        .CNT_WIDTH   (12),
        .PIXEL_WIDTH (PW)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_pixel_data  (data),
        .i_pixel_last  (last),
        .i_pixel_valid (valid),
        .o_pixel_ready (ready),
        .o_serial      (serial),
        .o_busy        (busy),
`ifdef WS2812_UNDERRUN_FLAG_EN
        .o_underrun    (underrun),
`endif
        .o_dbg_state   (dbg_state)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- reference model / scoreboard ----------------
    // Entry bits: [2] serial, [1] busy, [0] last cycle of a non-last pixel.
    logic [2:0] exp_q[$];
    logic [2:0] cur_e;
    logic       prev_eop = 1'b0;
    logic       prev_ser = 1'b0;
    logic       prev_busy = 1'b0;
    int         cyc = 0;
    int         hs_cyc = -1;
    int         rise_q[$];
    int         fall_q[$];
    int         bfall_q[$];
    int         ur_q[$];

    // Appends the waveform of one accepted pixel. An idle encoder needs one
    // cycle to see the held pixel before the first high phase.
    function automatic void model_push(input logic [PW-1:0] d, input logic l);
        int hi;
        int lo;
        if (exp_q.size() == 0) exp_q.push_back(3'b000);
        for (int b = PW - 1; b >= 0; b--) begin
            hi = d[b] ? B_T1H : B_T0H;
            lo = B_BIT - hi;
            for (int i = 0; i < hi; i++) exp_q.push_back(3'b110);
            for (int i = 0; i < lo; i++)
                exp_q.push_back((b == 0 && !l && i == lo - 1) ? 3'b011 : 3'b010);
        end
        if (l) begin
            for (int i = 0; i < B_LATCH; i++) exp_q.push_back(3'b010);
            exp_q.push_back(3'b000);
        end
    endfunction

    // Per-cycle compare plus edge-time recorder, sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_eop = 1'b0;
            check($sformatf("reset_outputs@%0d", cyc), {29'd0, serial, busy, ready}, 32'd1);
        end else begin
            cur_e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
            check($sformatf("wave@%0d", cyc), {30'd0, serial, busy}, {30'd0, cur_e[2:1]});
`ifdef WS2812_UNDERRUN_FLAG_EN
            check($sformatf("underrun@%0d", cyc), {31'd0, underrun}, {31'd0, prev_eop && !cur_e[1]});
            if (underrun) ur_q.push_back(cyc);
`endif
            prev_eop = cur_e[0];
            if (valid && ready) begin
                model_push(data, last);
                hs_cyc = cyc;
            end
        end
        if (serial && !prev_ser) rise_q.push_back(cyc);
        if (!serial && prev_ser) fall_q.push_back(cyc);
        if (!busy && prev_busy) bfall_q.push_back(cyc);
        prev_ser  = serial;
        prev_busy = busy;
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents a pixel and returns just after the edge that transfers it.
    task automatic send_pixel(input logic [PW-1:0] d, input logic l);
        int w;
        data  = d;
        last  = l;
        valid = 1'b1;
        w     = 0;
        @(negedge clk);
        while (!ready && w < 5000) begin
            @(negedge clk);
            w++;
        end
        if (!ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            valid = 1'b0;
            @(posedge clk);
            #1;
        end else begin
            @(posedge clk);
            #1;
            valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (!(exp_q.size() == 0 && !busy && ready) && w < 9000) begin
            wait_cyc(1);
            w++;
        end
        if (w >= 9000) check("idle_timeout", 32'd0, 32'd1);
        wait_cyc(2);
    endtask

    task automatic clear_edges();
        rise_q.delete();
        fall_q.delete();
        bfall_q.delete();
        ur_q.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [PW-1:0] d;
        int            hi0;
        int            lo0;
        int            hi1;
        int            frame;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #200_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        int r;
        logic [PW-1:0] rd;
        logic          rl;

        tbl[0] = '{24'hAA0000, 40, 22, 20, B_PIX + B_LATCH};
        tbl[1] = '{24'h000001, 20, 42, 20, B_PIX + B_LATCH};
        tbl[2] = '{24'h7FFFFF, 20, 42, 40, B_PIX + B_LATCH};
        tbl[3] = '{24'hC00000, 40, 22, 40, B_PIX + B_LATCH};

        // Reset, then a long quiet period with valid low.
        rst_n = 1'b0;
        wait_cyc(5);
        rst_n = 1'b1;
        check("ready_after_reset", {31'd0, ready}, 32'd1);
        check("serial_after_reset", {31'd0, serial}, 32'd0);
        check("busy_after_reset", {31'd0, busy}, 32'd0);
        check("state_after_reset", 32'(dbg_state), 32'(IDLE));
        wait_cyc(5000);

        // Single frame-last pixels: first-bit shape, latency and frame length.
        for (int k = 0; k < 4; k++) begin
            clear_edges();
            send_pixel(tbl[k].d, 1'b1);
            hs = hs_cyc;
            wait_idle();
            if (rise_q.size() >= 2 && fall_q.size() >= 2 && bfall_q.size() >= 1) begin
                check($sformatf("latency_%0d", k), rise_q[0] - hs, 2);
                check($sformatf("hi0_%0d", k), fall_q[0] - rise_q[0], tbl[k].hi0);
                check($sformatf("lo0_%0d", k), rise_q[1] - fall_q[0], tbl[k].lo0);
                check($sformatf("hi1_%0d", k), fall_q[1] - rise_q[1], tbl[k].hi1);
                check($sformatf("frame_%0d", k), bfall_q[0] - rise_q[0], tbl[k].frame);
            end else begin
                check($sformatf("edges_seen_%0d", k), 32'd0, 32'd1);
            end
        end

        // Back-to-back with valid held: no gap between pixels.
        clear_edges();
        send_pixel(24'hFFFFFF, 1'b0);
        send_pixel(24'h000000, 1'b1);
        check("ready_after_second_accept", {31'd0, ready}, 32'd0);
        wait_idle();
        if (rise_q.size() >= 25 && fall_q.size() >= 25) begin
            check("b2b_second_start", rise_q[24] - rise_q[0], B_PIX);
            check("b2b_second_hi", fall_q[24] - rise_q[24], B_T0H);
        end else begin
            check("b2b_edges_seen", 32'd0, 32'd1);
        end

        // Pixel offered during the latch period.
        clear_edges();
        send_pixel(24'h0F0F0F, 1'b1);
        wait_cyc(B_PIX + 1000);
        check("ready_in_latch", {31'd0, ready}, 32'd1);
        check("busy_in_latch", {31'd0, busy}, 32'd1);
        check("state_in_latch", 32'(dbg_state), 32'(LATCH));
        send_pixel(24'hF00000, 1'b1);
        wait_idle();
        if (rise_q.size() >= 13) begin
            // 0x0F0F0F has 12 one bits... first rise of the next pixel is
            // the 25th rise overall (every bit starts with a rise).
            if (rise_q.size() >= 25)
                check("latch_next_start", rise_q[24] - rise_q[0], B_PIX + B_LATCH + 1);
            else
                check("latch_edges_seen", 32'd0, 32'd1);
        end else begin
            check("latch_edges_seen", 32'd0, 32'd1);
        end

        // Underrun: non-last pixel with nothing following.
        clear_edges();
        send_pixel(24'h123456, 1'b0);
        wait_cyc(B_PIX + 20);
        check("underrun_serial", {31'd0, serial}, 32'd0);
        check("underrun_state", 32'(dbg_state), 32'(IDLE));
        if (rise_q.size() >= 1 && bfall_q.size() >= 1)
            check("underrun_busy_fall", bfall_q[0] - rise_q[0], B_PIX);
        else
            check("underrun_edges_seen", 32'd0, 32'd1);
`ifdef WS2812_UNDERRUN_FLAG_EN
        check("underrun_pulses", ur_q.size(), 1);
        if (ur_q.size() >= 1 && rise_q.size() >= 1)
            check("underrun_time", ur_q[0] - rise_q[0], B_PIX);
`endif
        wait_idle();

        // Asynchronous reset in the middle of the high phase of bit 10,
        // with a second pixel waiting in the holding register.
        clear_edges();
        send_pixel(24'hFFFFFF, 1'b1);
        send_pixel(24'h00FF00, 1'b1);
        if (rise_q.size() >= 1) begin
            r = rise_q[0];
            while (cyc < r + 13 * B_BIT + 10) wait_cyc(1);
            check("serial_before_reset", {31'd0, serial}, 32'd1);
            #1;
            rst_n = 1'b0;
            #1;
            check("serial_async_reset", {31'd0, serial}, 32'd0);
            check("busy_async_reset", {31'd0, busy}, 32'd0);
            check("ready_async_reset", {31'd0, ready}, 32'd1);
            wait_cyc(3);
            rst_n = 1'b1;
            wait_cyc(10);
            check("held_pixel_discarded", {31'd0, busy}, 32'd0);
        end else begin
            check("reset_test_rise_seen", 32'd0, 32'd1);
        end
        clear_edges();
        send_pixel(24'h800000, 1'b1);
        hs = hs_cyc;
        wait_idle();
        if (rise_q.size() >= 1 && fall_q.size() >= 1) begin
            check("post_reset_latency", rise_q[0] - hs, 2);
            check("post_reset_msb_hi", fall_q[0] - rise_q[0], B_T1H);
        end else begin
            check("post_reset_edges_seen", 32'd0, 32'd1);
        end

        // Randomized stream against the reference waveform.
        for (int k = 0; k < 8; k++) begin
            rd = 24'($urandom);
            rl = (k == 7) || ($urandom_range(0, 3) == 0);
            send_pixel(rd, rl);
            case ($urandom_range(0, 3))
                0: ;
                1: wait_cyc($urandom_range(1, 5));
                2: wait_cyc($urandom_range(B_PIX - 8, B_PIX + 6));
                default: wait_cyc($urandom_range(100, 600));
            endcase
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
